// File: rtl/ddram_arbiter_nch.sv
// rtl/ddram_arbiter_nch.sv - N-channel DDRAM Avalon arbiter with per-channel read-prefetch line cache
// Write hits on any channel's line are merged in place so cached reads stay coherent.
module ddram_arbiter_nch #(
  parameter int NCH = 4,
  parameter int PREFETCH = 2,
  parameter logic [NCH-1:0] CACHE_EN = '1,
  parameter bit RR = 1'b0,
  parameter logic [3:0] BASE = 4'b0011
) (
  input  logic                DDRAM_CLK,
  input  logic                reset,
  input  logic                DDRAM_BUSY,
  output logic [7:0]          DDRAM_BURSTCNT,
  output logic [28:0]         DDRAM_ADDR,
  input  logic [63:0]         DDRAM_DOUT,
  input  logic                DDRAM_DOUT_READY,
  output logic                DDRAM_RD,
  output logic [63:0]         DDRAM_DIN,
  output logic [7:0]          DDRAM_BE,
  output logic                DDRAM_WE,
  input  logic [NCH*25-1:0]   ch_addr,
  input  logic [NCH*64-1:0]   ch_din,
  input  logic [NCH*8-1:0]    ch_be,
  input  logic [NCH-1:0]      ch_req,
  input  logic [NCH-1:0]      ch_rnw,
  output logic [NCH*64-1:0]   ch_dout,
  output logic [NCH-1:0]      ch_ready
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int OW = (PREFETCH > 1) ? $clog2(PREFETCH) : 1;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t          state;
  logic [NCH-1:0]  pending, lat_rnw, line_valid;
  logic [24:0]     lat_addr [NCH];
  logic [63:0]     lat_din [NCH];
  logic [7:0]      lat_be [NCH];
  logic [24:0]     line_tag [NCH];
  logic [63:0]     line_data [NCH][PREFETCH];
  logic [63:0]     ch_dout_r [NCH];
  logic [IW-1:0]   rr_ptr, cur_ch, gnt;
  logic [3:0]      beat;

  logic [NCH-1:0]  pend_eff, eff_rnw, w_hit;
  logic [24:0]     eff_addr [NCH];
  logic [63:0]     eff_din [NCH];
  logic [7:0]      eff_be [NCH];
  logic [OW-1:0]   w_off [NCH];
  logic            grant_vld, g_hit;
  logic [24:0]     g_addr;
  logic [OW-1:0]   g_off;

  // 26-bit compare so a line whose range crosses 2^25 never hits on wrapped addresses
  function automatic logic in_line(input logic [24:0] a, input logic [24:0] tag);
    return ({1'b0, a} >= {1'b0, tag}) && ({1'b0, a} < ({1'b0, tag} + 26'(PREFETCH)));
  endfunction

  function automatic logic [63:0] merge64(input logic [63:0] old, input logic [63:0] din,
                                          input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (be[b]) r[b*8 +: 8] = din[b*8 +: 8];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pend_eff[i] = pending[i] | ch_req[i];
      eff_addr[i] = ch_req[i] ? ch_addr[i*25 +: 25] : lat_addr[i];
      eff_din[i]  = ch_req[i] ? ch_din[i*64 +: 64] : lat_din[i];
      eff_be[i]   = ch_req[i] ? ch_be[i*8 +: 8] : lat_be[i];
      eff_rnw[i]  = ch_req[i] ? ch_rnw[i] : lat_rnw[i];
    end
  end

  // Scan from lowest to highest priority so the last match wins
  always_comb begin
    int idx;
    logic [IW-1:0] sel;
    grant_vld = 1'b0;
    gnt = '0;
    idx = 0;
    sel = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = RR ? (int'(rr_ptr) + 1 + k) : k;
      if (idx >= NCH) idx = idx - NCH;
      sel = IW'(idx);
      if (pend_eff[sel]) begin
        grant_vld = 1'b1;
        gnt = sel;
      end
    end
  end

  always_comb begin
    g_addr = eff_addr[gnt];
    g_off  = OW'(g_addr - line_tag[gnt]);
    g_hit  = CACHE_EN[gnt] && line_valid[gnt] && in_line(g_addr, line_tag[gnt]);
    for (int i = 0; i < NCH; i++) begin
      w_hit[i] = line_valid[i] && in_line(g_addr, line_tag[i]);
      w_off[i] = OW'(g_addr - line_tag[i]);
    end
  end

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      DDRAM_RD       <= 1'b0;
      DDRAM_WE       <= 1'b0;
      DDRAM_BURSTCNT <= 8'd1;
      DDRAM_BE       <= 8'd0;
      DDRAM_ADDR     <= {BASE, 25'd0};
      DDRAM_DIN      <= 64'd0;
      ch_ready       <= '0;
      pending        <= '0;
      lat_rnw        <= '0;
      line_valid     <= '0;
      rr_ptr         <= '0;
      cur_ch         <= '0;
      beat           <= '0;
      for (int i = 0; i < NCH; i++) begin
        lat_addr[i]  <= '0;
        lat_din[i]   <= '0;
        lat_be[i]    <= '0;
        line_tag[i]  <= '0;
        ch_dout_r[i] <= '0;
      end
    end else begin
      ch_ready <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (ch_req[i]) begin
          pending[i]  <= 1'b1;
          lat_addr[i] <= ch_addr[i*25 +: 25];
          lat_din[i]  <= ch_din[i*64 +: 64];
          lat_be[i]   <= ch_be[i*8 +: 8];
          lat_rnw[i]  <= ch_rnw[i];
        end
      end
      if (!DDRAM_BUSY) begin
        DDRAM_RD <= 1'b0;
        DDRAM_WE <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!DDRAM_BUSY && grant_vld) begin
            pending[gnt] <= 1'b0;
            rr_ptr <= gnt;
            cur_ch <= gnt;
            if (!eff_rnw[gnt]) begin
              DDRAM_WE       <= 1'b1;
              DDRAM_BURSTCNT <= 8'd1;
              DDRAM_ADDR     <= {BASE, g_addr};
              DDRAM_BE       <= eff_be[gnt];
              DDRAM_DIN      <= eff_din[gnt];
              ch_ready[gnt]  <= 1'b1;
            end else if (g_hit) begin
              ch_dout_r[gnt] <= line_data[gnt][g_off];
              ch_ready[gnt]  <= 1'b1;
            end else begin
              DDRAM_RD       <= 1'b1;
              DDRAM_BURSTCNT <= CACHE_EN[gnt] ? 8'(PREFETCH) : 8'd1;
              DDRAM_ADDR     <= {BASE, g_addr};
              beat           <= '0;
              state          <= RD_WAIT;
              if (CACHE_EN[gnt]) begin
                line_tag[gnt]   <= g_addr;
                line_valid[gnt] <= 1'b0;
              end
            end
          end
        end
        RD_WAIT: begin
          if (DDRAM_DOUT_READY) begin
            beat <= beat + 4'd1;
            if (beat == 4'd0) begin
              ch_dout_r[cur_ch] <= DDRAM_DOUT;
              ch_ready[cur_ch]  <= 1'b1;
            end
            if (!CACHE_EN[cur_ch] || beat == 4'(PREFETCH - 1)) begin
              state <= IDLE;
              if (CACHE_EN[cur_ch]) line_valid[cur_ch] <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Line storage carries no reset; validity alone decides whether contents are used
  always_ff @(posedge DDRAM_CLK) begin
    if (state == IDLE && !DDRAM_BUSY && grant_vld && !eff_rnw[gnt]) begin
      for (int i = 0; i < NCH; i++)
        if (w_hit[i]) line_data[i][w_off[i]] <= merge64(line_data[i][w_off[i]], eff_din[gnt], eff_be[gnt]);
    end
    if (state == RD_WAIT && DDRAM_DOUT_READY && CACHE_EN[cur_ch])
      line_data[cur_ch][beat[OW-1:0]] <= DDRAM_DOUT;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) ch_dout[i*64 +: 64] = ch_dout_r[i];
  end
endmodule

// File: tb/tb_ddram_arbiter_nch.sv
// tb/tb_ddram_arbiter_nch.sv - directed self-checking bench for ddram_arbiter_nch
// Instance a: fixed priority; instance b: round-robin; both share stimulus.
module tb_ddram_arbiter_nch;
  localparam logic [3:0] BASE = 4'b0011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, busy, dout_ready;
  logic [63:0] dout;
  logic [99:0] ch_addr;
  logic [255:0] ch_din;
  logic [31:0] ch_be;
  logic [3:0] ch_req, ch_rnw;

  logic [7:0] bc_a, be_a, bc_b, be_b;
  logic [28:0] addr_a, addr_b;
  logic rd_a, we_a, rd_b, we_b;
  logic [63:0] din_a, din_b;
  logic [255:0] chd_a, chd_b;
  logic [3:0] rdy_a, rdy_b;

  int checks = 0;
  int errors = 0;

  ddram_arbiter_nch #(.NCH(4), .PREFETCH(4), .CACHE_EN(4'b1111), .RR(1'b0), .BASE(BASE)) dut_a (
    .DDRAM_CLK(clk), .reset(reset), .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(bc_a), .DDRAM_ADDR(addr_a),
    .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(dout_ready), .DDRAM_RD(rd_a), .DDRAM_DIN(din_a),
    .DDRAM_BE(be_a), .DDRAM_WE(we_a), .ch_addr(ch_addr), .ch_din(ch_din), .ch_be(ch_be),
    .ch_req(ch_req), .ch_rnw(ch_rnw), .ch_dout(chd_a), .ch_ready(rdy_a));

  ddram_arbiter_nch #(.NCH(4), .PREFETCH(4), .CACHE_EN(4'b1111), .RR(1'b1), .BASE(BASE)) dut_b (
    .DDRAM_CLK(clk), .reset(reset), .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(bc_b), .DDRAM_ADDR(addr_b),
    .DDRAM_DOUT(dout), .DDRAM_DOUT_READY(dout_ready), .DDRAM_RD(rd_b), .DDRAM_DIN(din_b),
    .DDRAM_BE(be_b), .DDRAM_WE(we_b), .ch_addr(ch_addr), .ch_din(ch_din), .ch_be(ch_be),
    .ch_req(ch_req), .ch_rnw(ch_rnw), .ch_dout(chd_b), .ch_ready(rdy_b));

  task automatic set_ch(input int c, input logic [24:0] a, input logic [63:0] d,
                        input logic [7:0] be, input logic rnw);
    ch_addr[c*25 +: 25] = a;
    ch_din[c*64 +: 64] = d;
    ch_be[c*8 +: 8] = be;
    ch_rnw[c] = rnw;
  endtask

  task automatic request(input logic [3:0] r);
    ch_req = r;
    @(negedge clk);
    ch_req = 4'b0000;
  endtask

  task automatic feed(input logic [63:0] d);
    dout = d;
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; busy = 1'b0; dout_ready = 1'b0; dout = '0;
    ch_req = '0; ch_rnw = '0; ch_addr = '0; ch_din = '0; ch_be = '0;
    repeat (2) @(negedge clk);
    checks++; if ({rd_a, we_a} !== 2'b00) begin errors++; $display("FAIL rst_rdwe: got %b expected 00", {rd_a, we_a}); end
    checks++; if (bc_a !== 8'd1) begin errors++; $display("FAIL rst_burstcnt: got %h expected 01", bc_a); end
    checks++; if (addr_a !== {BASE, 25'd0}) begin errors++; $display("FAIL rst_addr: got %h expected %h", addr_a, {BASE, 25'd0}); end
    checks++; if ({be_a, din_a} !== 72'd0) begin errors++; $display("FAIL rst_be_din: got %h expected 0", {be_a, din_a}); end
    checks++; if (rdy_a !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b expected 0000", rdy_a); end
    checks++; if (chd_a !== 256'd0) begin errors++; $display("FAIL rst_dout: got %h expected 0", chd_a); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority;
    set_ch(0, 25'h10, 64'h1122334455667788, 8'h0F, 1'b0);
    set_ch(2, 25'h10, 64'd0, 8'h00, 1'b1);
    request(4'b0101);
    checks++; if ({we_a, rd_a} !== 2'b10) begin errors++; $display("FAIL fp_we_first: got we/rd %b expected 10", {we_a, rd_a}); end
    checks++; if (addr_a !== {BASE, 25'h10}) begin errors++; $display("FAIL fp_wr_addr: got %h expected %h", addr_a, {BASE, 25'h10}); end
    checks++; if (be_a !== 8'h0F || din_a !== 64'h1122334455667788 || bc_a !== 8'd1) begin
      errors++; $display("FAIL fp_wr_fields: got be %h din %h bc %h expected 0f 1122334455667788 01", be_a, din_a, bc_a); end
    checks++; if (rdy_a !== 4'b0001) begin errors++; $display("FAIL fp_wr_ready: got %b expected 0001", rdy_a); end
    @(negedge clk);
    checks++; if ({rd_a, we_a} !== 2'b10 || bc_a !== 8'd4) begin
      errors++; $display("FAIL fp_rd_issue: got rd/we %b bc %h expected 10 04", {rd_a, we_a}, bc_a); end
    checks++; if (addr_a !== {BASE, 25'h10}) begin errors++; $display("FAIL fp_rd_addr: got %h expected %h", addr_a, {BASE, 25'h10}); end
    feed(64'hC0);
    checks++; if (rdy_a !== 4'b0100 || chd_a[128 +: 64] !== 64'hC0) begin
      errors++; $display("FAIL fp_rd_beat0: got ready %b data %h expected 0100 c0", rdy_a, chd_a[128 +: 64]); end
    checks++; if (rd_a !== 1'b0) begin errors++; $display("FAIL fp_rd_deassert: got %b expected 0", rd_a); end
    for (int k = 1; k < 4; k++) begin
      feed(64'hC0 + 64'(k));
      checks++; if (rdy_a !== 4'b0000) begin errors++; $display("FAIL fp_rd_beat%0d_ready: got %b expected 0000", k, rdy_a); end
    end
  endtask

  task automatic test_cache;
    logic [63:0] dk;
    set_ch(1, 25'h100, 64'd0, 8'h00, 1'b1);
    request(4'b0010);
    checks++; if (rd_a !== 1'b1 || bc_a !== 8'd4 || addr_a !== {BASE, 25'h100}) begin
      errors++; $display("FAIL cache_miss_issue: got rd %b bc %h addr %h expected 1 04 %h", rd_a, bc_a, addr_a, {BASE, 25'h100}); end
    for (int k = 0; k < 4; k++) begin
      dk = {56'h01020304050607, 8'hF0 + 8'(k)};
      feed(dk);
      if (k == 0) begin
        checks++; if (rdy_a !== 4'b0010 || chd_a[64 +: 64] !== 64'h01020304050607F0) begin
          errors++; $display("FAIL cache_beat0: got ready %b data %h expected 0010 01020304050607f0", rdy_a, chd_a[64 +: 64]); end
      end
    end
    for (int k = 1; k < 4; k++) begin
      dk = {56'h01020304050607, 8'hF0 + 8'(k)};
      set_ch(1, 25'h100 + 25'(k), 64'd0, 8'h00, 1'b1);
      request(4'b0010);
      checks++; if (rdy_a !== 4'b0010 || rd_a !== 1'b0 || chd_a[64 +: 64] !== dk) begin
        errors++; $display("FAIL cache_hit_%0d: got ready %b rd %b data %h expected 0010 0 %h", k, rdy_a, rd_a, chd_a[64 +: 64], dk); end
    end
  endtask

  task automatic test_coherence;
    set_ch(3, 25'h102, 64'hFFFFFFFFFFFFFFAA, 8'h01, 1'b0);
    request(4'b1000);
    checks++; if (we_a !== 1'b1 || addr_a !== {BASE, 25'h102} || be_a !== 8'h01 || rdy_a !== 4'b1000) begin
      errors++; $display("FAIL coh_write: got we %b addr %h be %h ready %b expected 1 %h 01 1000", we_a, addr_a, be_a, rdy_a, {BASE, 25'h102}); end
    set_ch(1, 25'h102, 64'd0, 8'h00, 1'b1);
    request(4'b0010);
    checks++; if (rdy_a !== 4'b0010 || rd_a !== 1'b0 || chd_a[64 +: 64] !== 64'h01020304050607AA) begin
      errors++; $display("FAIL coh_merged: got ready %b rd %b data %h expected 0010 0 01020304050607aa", rdy_a, rd_a, chd_a[64 +: 64]); end
  endtask

  task automatic test_new_burst;
    set_ch(1, 25'h104, 64'd0, 8'h00, 1'b1);
    request(4'b0010);
    checks++; if (rd_a !== 1'b1 || bc_a !== 8'd4 || addr_a !== {BASE, 25'h104}) begin
      errors++; $display("FAIL nb_issue: got rd %b bc %h addr %h expected 1 04 %h", rd_a, bc_a, addr_a, {BASE, 25'h104}); end
    for (int k = 0; k < 4; k++) feed(64'hE0 + 64'(k));
    set_ch(1, 25'h107, 64'd0, 8'h00, 1'b1);
    request(4'b0010);
    checks++; if (rdy_a !== 4'b0010 || rd_a !== 1'b0 || chd_a[64 +: 64] !== 64'hE3) begin
      errors++; $display("FAIL nb_top_hit: got ready %b rd %b data %h expected 0010 0 e3", rdy_a, rd_a, chd_a[64 +: 64]); end
    set_ch(1, 25'h103, 64'd0, 8'h00, 1'b1);
    request(4'b0010);
    checks++; if (rd_a !== 1'b1 || addr_a !== {BASE, 25'h103} || rdy_a !== 4'b0000) begin
      errors++; $display("FAIL nb_below_miss: got rd %b addr %h ready %b expected 1 %h 0000", rd_a, addr_a, rdy_a, {BASE, 25'h103}); end
    for (int k = 0; k < 4; k++) feed(64'hF0 + 64'(k));
  endtask

  task automatic test_wrap;
    set_ch(2, 25'h1FFFFFE, 64'd0, 8'h00, 1'b1);
    request(4'b0100);
    checks++; if (rd_a !== 1'b1 || addr_a !== {BASE, 25'h1FFFFFE}) begin
      errors++; $display("FAIL wrap_issue: got rd %b addr %h expected 1 %h", rd_a, addr_a, {BASE, 25'h1FFFFFE}); end
    for (int k = 0; k < 4; k++) feed(64'h50 + 64'(k));
    set_ch(2, 25'h1FFFFFF, 64'd0, 8'h00, 1'b1);
    request(4'b0100);
    checks++; if (rdy_a !== 4'b0100 || rd_a !== 1'b0 || chd_a[128 +: 64] !== 64'h51) begin
      errors++; $display("FAIL wrap_hit: got ready %b rd %b data %h expected 0100 0 51", rdy_a, rd_a, chd_a[128 +: 64]); end
    set_ch(2, 25'h0, 64'd0, 8'h00, 1'b1);
    request(4'b0100);
    checks++; if (rd_a !== 1'b1 || addr_a !== {BASE, 25'h0} || rdy_a !== 4'b0000) begin
      errors++; $display("FAIL wrap_no_hit: got rd %b addr %h ready %b expected 1 %h 0000", rd_a, addr_a, rdy_a, {BASE, 25'h0}); end
    for (int k = 0; k < 4; k++) feed(64'h60 + 64'(k));
  endtask

  task automatic test_round_robin;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) set_ch(c, 25'h200 + 25'(c), 64'h1000 + 64'(c), 8'hFF, 1'b0);
    request(4'b1000);
    checks++; if (we_b !== 1'b1 || addr_b !== {BASE, 25'h203}) begin
      errors++; $display("FAIL rr_first: got we %b addr %h expected 1 %h", we_b, addr_b, {BASE, 25'h203}); end
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (addr_b !== {BASE, 25'h200 + 25'(exp_seq[k])} || rdy_b !== (4'b0001 << exp_seq[k])) begin
        errors++; $display("FAIL rr_grant_%0d: got addr %h ready %b expected channel %0d", k, addr_b, rdy_b, exp_seq[k]); end
    end
    busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (we_b !== 1'b1 || addr_b !== {BASE, 25'h200} || din_b !== 64'h1000 || be_b !== 8'hFF || bc_b !== 8'd1 || rdy_b !== 4'b0000) begin
        errors++; $display("FAIL rr_busy_hold_%0d: got we %b addr %h din %h be %h bc %h ready %b expected 1 %h 1000 ff 01 0000",
                           k, we_b, addr_b, din_b, be_b, bc_b, rdy_b, {BASE, 25'h200}); end
    end
    busy = 1'b0;
    @(negedge clk);
    ch_req = 4'b0000;
    checks++; if (addr_b !== {BASE, 25'h201} || rdy_b !== 4'b0010) begin
      errors++; $display("FAIL rr_after_busy: got addr %h ready %b expected %h 0010", addr_b, rdy_b, {BASE, 25'h201}); end
  endtask

  task automatic test_reset_midburst;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_ch(1, 25'h300, 64'd0, 8'h00, 1'b1);
    request(4'b0010);
    checks++; if (rd_a !== 1'b1 || bc_a !== 8'd4) begin errors++; $display("FAIL mb_issue: got rd %b bc %h expected 1 04", rd_a, bc_a); end
    feed(64'h300);
    checks++; if (rdy_a !== 4'b0010 || chd_a[64 +: 64] !== 64'h300) begin
      errors++; $display("FAIL mb_beat0: got ready %b data %h expected 0010 300", rdy_a, chd_a[64 +: 64]); end
    feed(64'h301);
    dout = 64'h302;
    dout_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    checks++; if (bc_a !== 8'd1 || addr_a !== {BASE, 25'd0} || rd_a !== 1'b0 || chd_a !== 256'd0 || rdy_a !== 4'b0000) begin
      errors++; $display("FAIL mb_async_reset: got bc %h addr %h rd %b dout %h ready %b", bc_a, addr_a, rd_a, chd_a[64 +: 64], rdy_a); end
    @(negedge clk);
    reset = 1'b0;
    dout = 64'hBAD;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (rdy_a !== 4'b0000 || rd_a !== 1'b0) begin
        errors++; $display("FAIL mb_stray_%0d: got ready %b rd %b expected 0000 0", k, rdy_a, rd_a); end
    end
    dout_ready = 1'b0;
    request(4'b0010);
    checks++; if (rd_a !== 1'b1 || addr_a !== {BASE, 25'h300} || bc_a !== 8'd4) begin
      errors++; $display("FAIL mb_reissue: got rd %b addr %h bc %h expected 1 %h 04", rd_a, addr_a, bc_a, {BASE, 25'h300}); end
    for (int k = 0; k < 4; k++) begin
      feed(64'h400 + 64'(k));
      if (k == 0) begin
        checks++; if (rdy_a !== 4'b0010 || chd_a[64 +: 64] !== 64'h400) begin
          errors++; $display("FAIL mb_refill_beat0: got ready %b data %h expected 0010 400", rdy_a, chd_a[64 +: 64]); end
      end
    end
    set_ch(1, 25'h302, 64'd0, 8'h00, 1'b1);
    request(4'b0010);
    checks++; if (rdy_a !== 4'b0010 || rd_a !== 1'b0 || chd_a[64 +: 64] !== 64'h402) begin
      errors++; $display("FAIL mb_refill_hit: got ready %b rd %b data %h expected 0010 0 402", rdy_a, rd_a, chd_a[64 +: 64]); end
  endtask

  initial begin
    test_reset;
    test_fixed_priority;
    test_cache;
    test_coherence;
    test_new_burst;
    test_wrap;
    test_round_robin;
    test_reset_midburst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
